rename: RTL and testbench

RENAME -- requirements
Module: rename

---
 rtl/rename_pkg.sv | 51 +++++
 rtl/rename_free_list.sv | 61 ++++++
 rtl/rename.sv | 105 ++++++++++
 tb/tb_rename.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename stage.
package C;

   localparam int ARFSIZE         = 32;
   localparam int AREG_ID_BITS    = 5;
   localparam int PRFSIZE         = 8;
   localparam int PREG_ID_BITS    = 3;
   localparam int ID_BITS         = 4;
   localparam int NR_COMMIT_PORTS = 2;

   typedef struct packed {
      logic [AREG_ID_BITS-1:0] rs1;
      logic [AREG_ID_BITS-1:0] rs2;
      logic [AREG_ID_BITS-1:0] rd;
      logic                    rd_valid;
      logic                    rs1_valid;
      logic                    rs2_valid;
      logic [31:0]             pc;
      logic [2:0]              fu;
      logic [3:0]              op;
      logic [31:0]             imm;
      logic                    use_uimm;
   } si_t;

   typedef struct packed {
      logic [ID_BITS-1:0]      id;
      si_t                     si;
      logic [PREG_ID_BITS-1:0] prs1;
      logic [PREG_ID_BITS-1:0] prs2;
      logic [PREG_ID_BITS-1:0] prd;
      logic                    prs1_renammed;
      logic                    prs2_renammed;
   } di_t;

   typedef struct packed {
      logic [AREG_ID_BITS-1:0] rd;
      logic                    rd_valid;
      logic [PREG_ID_BITS-1:0] prd;
   } commit_t;

   typedef struct packed {
      logic                    valid;
      logic [PREG_ID_BITS-1:0] preg;
   } map_entry_t;

   // x0 is hardwired, so it never owns a physical register.
   function automatic logic writes_reg(input logic rd_valid, input logic [AREG_ID_BITS-1:0] rd);
      return rd_valid && (rd != '0);
   endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical register ids: one pop, NR_COMMIT_PORTS ordered pushes per cycle.
// Reset and flush both restore it to full, holding 0..PRFSIZE-1 in order.
module free_list
   import C::*;
(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        flush,
   input  logic                                        pop,
   output logic [PREG_ID_BITS-1:0]                     head_id,
   input  logic [NR_COMMIT_PORTS-1:0]                  push,
   input  logic [NR_COMMIT_PORTS-1:0][PREG_ID_BITS-1:0] push_id,
   output logic [PREG_ID_BITS:0]                       count
);

   logic [PREG_ID_BITS-1:0] slots [PRFSIZE];
   logic [PREG_ID_BITS-1:0] head;
   logic [PREG_ID_BITS-1:0] tail;
   logic [PREG_ID_BITS-1:0] wr_idx [NR_COMMIT_PORTS];
   logic [PREG_ID_BITS:0]   npush;

   assign head_id = slots[head];

   // Each push lands after the pushes of the older ports in the same cycle.
   always_comb begin
      npush = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         wr_idx[k] = tail + npush[PREG_ID_BITS-1:0];
         npush     = npush + (PREG_ID_BITS+1)'(push[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < PRFSIZE; i++) begin
            slots[i] <= PREG_ID_BITS'(i);
         end
         head  <= '0;
         tail  <= '0;
         count <= (PREG_ID_BITS+1)'(PRFSIZE);
      end else begin
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (push[k]) begin
               slots[wr_idx[k]] <= push_id[k];
            end
         end
         head  <= head + PREG_ID_BITS'(pop);
         tail  <= tail + npush[PREG_ID_BITS-1:0];
         count <= count - (PREG_ID_BITS+1)'(pop) + npush;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(pop && count == '0));
         assert (({1'b0, count} + {1'b0, npush}) <=
                 ((PREG_ID_BITS+2)'(PRFSIZE) + (PREG_ID_BITS+2)'(pop)));
      end
   end

endmodule

// File: rtl/rename.sv
// Register rename: maps architectural regs to physical regs, one instruction per cycle,
// registered output (1 cycle latency); stalls upstream when the output is blocked or no free preg.
module rename
   import C::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  si_t                                si_i,
   input  logic                               si_i_valid,
   output logic                               si_i_ready,
   output di_t                                di_o,
   output logic                               di_o_valid,
   input  logic                               di_o_ready,
   input  commit_t [NR_COMMIT_PORTS-1:0]      commit_i,
   input  logic [NR_COMMIT_PORTS-1:0]         commit_i_valid,
   input  logic                               flush_i
);

   map_entry_t                                  map_q [ARFSIZE];
   logic [ID_BITS-1:0]                          id_q;
   logic                                        need_rd;
   logic                                        accept;
   logic                                        pop;
   logic [PREG_ID_BITS-1:0]                     free_head;
   logic [PREG_ID_BITS:0]                       free_count;
   logic [NR_COMMIT_PORTS-1:0]                  push;
   logic [NR_COMMIT_PORTS-1:0][PREG_ID_BITS-1:0] push_id;
   di_t                                         next_di;

   assign need_rd    = writes_reg(si_i.rd_valid, si_i.rd);
   assign si_i_ready = !rst && (!di_o_valid || di_o_ready) &&
                       (!need_rd || free_count != '0) && !flush_i;
   assign accept     = si_i_valid && si_i_ready;
   assign pop        = accept && need_rd;

   always_comb begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         push[k]    = commit_i_valid[k] && !flush_i &&
                      writes_reg(commit_i[k].rd_valid, commit_i[k].rd);
         push_id[k] = commit_i[k].prd;
      end
   end

   free_list u_free_list (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_i),
      .pop     (pop),
      .head_id (free_head),
      .push    (push),
      .push_id (push_id),
      .count   (free_count)
   );

   // Source lookups read the map before this cycle's rename write lands.
   always_comb begin
      next_di               = '0;
      next_di.id            = id_q;
      next_di.si            = si_i;
      next_di.prs1          = map_q[si_i.rs1].preg;
      next_di.prs2          = map_q[si_i.rs2].preg;
      next_di.prs1_renammed = map_q[si_i.rs1].valid && (si_i.rs1 != '0);
      next_di.prs2_renammed = map_q[si_i.rs2].valid && (si_i.rs2 != '0);
      next_di.prd           = pop ? free_head : '0;
   end

   // The rename write is issued last so it wins over a same-cycle commit clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARFSIZE; i++) begin
            map_q[i] <= '0;
         end
      end else if (flush_i) begin
         for (int i = 0; i < ARFSIZE; i++) begin
            map_q[i].valid <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (push[k] && map_q[commit_i[k].rd].preg == commit_i[k].prd) begin
               map_q[commit_i[k].rd].valid <= 1'b0;
            end
         end
         if (pop) begin
            map_q[si_i.rd] <= '{valid: 1'b1, preg: free_head};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         di_o_valid <= 1'b0;
         di_o       <= '0;
         id_q       <= '0;
      end else if (flush_i) begin
         di_o_valid <= 1'b0;
      end else if (accept) begin
         di_o_valid <= 1'b1;
         di_o       <= next_di;
         id_q       <= id_q + 1'b1;
      end else if (di_o_ready) begin
         di_o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rename.sv
// Randomised and directed bench for rename against a queue-based behavioural model.
module tb_rename;
   import C::*;

   logic                          clk = 1'b0;
   logic                          rst;
   si_t                           si_i;
   logic                          si_i_valid;
   logic                          si_i_ready;
   di_t                           di_o;
   logic                          di_o_valid;
   logic                          di_o_ready;
   commit_t [NR_COMMIT_PORTS-1:0] commit_i;
   logic [NR_COMMIT_PORTS-1:0]    commit_i_valid;
   logic                          flush_i;

   always #5 clk = ~clk;

   rename dut (
      .clk            (clk),
      .rst            (rst),
      .si_i           (si_i),
      .si_i_valid     (si_i_valid),
      .si_i_ready     (si_i_ready),
      .di_o           (di_o),
      .di_o_valid     (di_o_valid),
      .di_o_ready     (di_o_ready),
      .commit_i       (commit_i),
      .commit_i_valid (commit_i_valid),
      .flush_i        (flush_i)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { int rd; int prd; } infl_t;

   bit    m_valid [ARFSIZE];
   int    m_preg  [ARFSIZE];
   int    fl [$];
   infl_t inflight [$];
   bit    exp_valid;
   di_t   exp_di;
   int    exp_id;
   bit    live = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      bit need;
      need = si_i.rd_valid && (si_i.rd != 0);
      return !rst && !flush_i && (!exp_valid || di_o_ready) && (!need || fl.size() != 0);
   endfunction

   function automatic void model_fill_free();
      fl.delete();
      for (int i = 0; i < PRFSIZE; i++) fl.push_back(i);
   endfunction

   always @(posedge clk) begin : model_upd
      bit  acc;
      bit  need;
      di_t nd;
      int  p;
      if (rst) begin
         for (int i = 0; i < ARFSIZE; i++) begin
            m_valid[i] = 0;
            m_preg[i]  = 0;
         end
         model_fill_free();
         inflight.delete();
         exp_valid = 0;
         exp_di    = '0;
         exp_id    = 0;
         live      = 1'b1;
      end else if (flush_i) begin
         for (int i = 0; i < ARFSIZE; i++) m_valid[i] = 0;
         model_fill_free();
         inflight.delete();
         exp_valid = 0;
      end else begin
         acc  = si_i_valid && model_ready();
         need = si_i.rd_valid && (si_i.rd != 0);
         p    = 0;
         nd   = '0;
         nd.id            = ID_BITS'(exp_id % (1 << ID_BITS));
         nd.si            = si_i;
         nd.prs1          = PREG_ID_BITS'(m_preg[si_i.rs1]);
         nd.prs2          = PREG_ID_BITS'(m_preg[si_i.rs2]);
         nd.prs1_renammed = m_valid[si_i.rs1] && (si_i.rs1 != 0);
         nd.prs2_renammed = m_valid[si_i.rs2] && (si_i.rs2 != 0);
         if (acc && need) begin
            p      = fl.pop_front();
            nd.prd = PREG_ID_BITS'(p);
         end
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (commit_i_valid[k] && commit_i[k].rd_valid && commit_i[k].rd != 0) begin
               fl.push_back(int'(commit_i[k].prd));
               if (m_preg[commit_i[k].rd] == int'(commit_i[k].prd)) m_valid[commit_i[k].rd] = 0;
            end
         end
         if (acc && need) begin
            m_valid[si_i.rd] = 1;
            m_preg[si_i.rd]  = p;
            inflight.push_back('{int'(si_i.rd), p});
         end
         if (acc) begin
            exp_valid = 1;
            exp_di    = nd;
            exp_id++;
         end else if (di_o_ready) begin
            exp_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("di_o_valid", di_o_valid, exp_valid);
         if (exp_valid) chk("di_o", di_o, exp_di);
         chk("si_i_ready", si_i_ready, model_ready());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      si_i_valid     = 0;
      si_i           = '0;
      commit_i       = '0;
      commit_i_valid = '0;
      flush_i        = 0;
      di_o_ready     = 1;
   endtask

   function automatic si_t mk(input int rd, input int rs1, input int rs2, input bit rdv);
      si_t s;
      s           = '0;
      s.rd        = AREG_ID_BITS'(rd);
      s.rs1       = AREG_ID_BITS'(rs1);
      s.rs2       = AREG_ID_BITS'(rs2);
      s.rd_valid  = rdv;
      s.rs1_valid = 1;
      s.rs2_valid = 1;
      s.pc        = $urandom;
      s.imm       = $urandom;
      s.op        = 4'($urandom);
      s.fu        = 3'($urandom);
      s.use_uimm  = 1'($urandom);
      return s;
   endfunction

   task automatic send(input si_t s);
      si_i       = s;
      si_i_valid = 1;
   endtask

   task automatic do_reset();
      rst = 1;
      idle();
      tick();
      tick();
      rst = 0;
   endtask

   task automatic commit_prd(input int port, input int prd);
      for (int i = 0; i < inflight.size(); i++) begin
         if (inflight[i].prd == prd) begin
            commit_i[port].rd       = AREG_ID_BITS'(inflight[i].rd);
            commit_i[port].rd_valid = 1;
            commit_i[port].prd      = PREG_ID_BITS'(prd);
            commit_i_valid[port]    = 1;
            inflight.delete(i);
            return;
         end
      end
      chk("commit_target_present", 0, 1);
   endtask

   initial begin
      di_t held;
      int  rds [5];

      // Reset state and the first two renames.
      do_reset();
      chk("rst_valid", di_o_valid, 0);
      chk("rst_di", di_o, 0);
      #1 chk("rst_ready", si_i_ready, 1);
      send(mk(1, 0, 0, 1));
      tick();
      chk("a1_valid", di_o_valid, 1);
      chk("a1_prd", di_o.prd, 0);
      chk("a1_id", di_o.id, 0);
      chk("a1_rn1", di_o.prs1_renammed, 0);
      send(mk(2, 1, 1, 1));
      tick();
      chk("a2_prs1", di_o.prs1, 0);
      chk("a2_prs2", di_o.prs2, 0);
      chk("a2_rn", {di_o.prs1_renammed, di_o.prs2_renammed}, 2'b11);
      chk("a2_prd", di_o.prd, 1);
      chk("a2_id", di_o.id, 1);
      si_i_valid = 0;

      // Exhaust the free list, then recover via a commit.
      do_reset();
      for (int i = 0; i < PRFSIZE; i++) begin
         send(mk(i + 1, 0, 0, 1));
         tick();
         chk("fill_prd", di_o.prd, i);
      end
      send(mk(9, 0, 0, 1));
      #1 chk("empty_stall", si_i_ready, 0);
      tick();
      chk("empty_handoff", di_o_valid, 0);
      send(mk(3, 0, 0, 0));
      #1 chk("nop_ready", si_i_ready, 1);
      tick();
      chk("nop_valid", di_o_valid, 1);
      chk("nop_prd", di_o.prd, 0);
      send(mk(9, 0, 0, 1));
      commit_prd(0, 3);
      #1 chk("commit_cycle_ready", si_i_ready, 0);
      tick();
      commit_i_valid = '0;
      #1 chk("after_commit_ready", si_i_ready, 1);
      tick();
      chk("recycled_prd", di_o.prd, 3);
      si_i_valid = 0;

      // Source equal to destination reads the old mapping.
      do_reset();
      rds = '{1, 3, 5, 0, 0};
      for (int i = 0; i < 3; i++) begin
         send(mk(rds[i], 0, 0, 1));
         tick();
      end
      chk("x5_prd", di_o.prd, 2);
      send(mk(5, 5, 5, 1));
      tick();
      chk("self_prs1", di_o.prs1, 2);
      chk("self_prs2", di_o.prs2, 2);
      chk("self_prd", di_o.prd, 3);
      send(mk(0, 5, 0, 0));
      tick();
      chk("self_newmap", {di_o.prs1_renammed, 2'b0, di_o.prs1}, {1'b1, 2'b0, 3'd3});
      si_i_valid = 0;

      // Stale commits keep the newer mapping; rename beats a same-cycle clear.
      do_reset();
      rds = '{1, 2, 3, 4, 1};
      for (int i = 0; i < 5; i++) begin
         send(mk(rds[i], 0, 0, 1));
         tick();
      end
      chk("x1_p4", di_o.prd, 4);
      si_i_valid = 0;
      commit_prd(0, 0);
      tick();
      commit_i_valid = '0;
      send(mk(0, 1, 0, 0));
      tick();
      chk("stale_prs1", di_o.prs1, 4);
      chk("stale_rn1", di_o.prs1_renammed, 1);
      send(mk(1, 0, 0, 1));
      commit_prd(1, 4);
      tick();
      commit_i_valid = '0;
      chk("race_prd", di_o.prd, 5);
      send(mk(0, 1, 0, 0));
      tick();
      chk("race_prs1", di_o.prs1, 5);
      chk("race_rn1", di_o.prs1_renammed, 1);
      si_i_valid = 0;

      // Output backpressure, then flush during the stall.
      do_reset();
      send(mk(1, 0, 0, 1));
      tick();
      held       = di_o;
      di_o_ready = 0;
      send(mk(2, 1, 0, 1));
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_ready", si_i_ready, 0);
         tick();
         chk("stall_held", di_o, held);
         chk("stall_valid", di_o_valid, 1);
      end
      flush_i = 1;
      tick();
      flush_i = 0;
      chk("flush_valid", di_o_valid, 0);
      di_o_ready = 1;
      tick();
      chk("post_flush_valid", di_o_valid, 1);
      chk("post_flush_rn1", di_o.prs1_renammed, 0);
      chk("post_flush_prd", di_o.prd, 0);
      chk("post_flush_id", di_o.id, 1);
      si_i_valid = 0;

      // Random traffic with in-order commits and occasional flushes.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         si_i_valid     = ($urandom_range(0, 3) != 0);
         si_i           = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 9) < 7);
         di_o_ready     = ($urandom_range(0, 3) != 0);
         commit_i       = '0;
         commit_i_valid = '0;
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
               commit_i[k].rd       = AREG_ID_BITS'(inflight[0].rd);
               commit_i[k].rd_valid = 1;
               commit_i[k].prd      = PREG_ID_BITS'(inflight[0].prd);
               commit_i_valid[k]    = 1;
               void'(inflight.pop_front());
            end else if ($urandom_range(0, 9) == 0) begin
               commit_i[k].rd       = AREG_ID_BITS'($urandom_range(0, 7));
               commit_i[k].rd_valid = 0;
               commit_i[k].prd      = PREG_ID_BITS'($urandom);
               commit_i_valid[k]    = 1;
            end
         end
         flush_i = ($urandom_range(0, 199) == 0);
         tick();
      end
      idle();
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
